// File: rtl/slice_reg_pkg.sv
// Shared types and slice arithmetic for the sliced-register write arbiter.
// Helpers work on a 64-bit word; callers zero-extend their inputs and keep the low DATA_W bits of the result.
package slice_reg_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_e;

   localparam int MAX_W = 64;
   typedef logic [MAX_W-1:0] word_t;

   // Mask of len ones starting at bit lsb; shifts past the word simply fall off.
   function automatic word_t slice_mask(input logic [7:0] lsb, input logic [7:0] len);
      word_t ones;
      ones = (len >= 8'(MAX_W)) ? '1 : ((word_t'(1) << len) - word_t'(1));
      return ones << lsb;
   endfunction

   function automatic word_t slice_merge(input word_t      old,
                                         input word_t      data,
                                         input logic [7:0] lsb,
                                         input logic [7:0] len);
      word_t m;
      m = slice_mask(lsb, len);
      return (old & ~m) | ((data << lsb) & m);
   endfunction

endpackage

// File: rtl/slice_reg_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester at or above ptr_i (with wrap) wins.
module rr_grant #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   input  logic             en_i,
   output logic [N-1:0]     gnt_o,
   output logic [PTR_W-1:0] idx_o
);

   logic found;
   int   j;

   // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr_i) + k) % N;
         if (en_i && !found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = PTR_W'(j);
         end
      end
   end

endmodule

// File: rtl/slice_reg_arbiter.sv
// Round-robin arbiter owning one DATA_W-bit register written by partial slices, with a clear that
// outranks writes and a CLR_HOLD-cycle lockout. Requires DATA_W <= 64 and OFF_W <= 8.
module slice_reg_arbiter
   import slice_reg_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 14,
   parameter int OFF_W    = 4,
   parameter int CLR_HOLD = 2
) (
   input  logic                      clock_0,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*OFF_W-1:0]    req_lsb,
   input  logic [N_REQ*OFF_W-1:0]    req_len,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [DATA_W-1:0]         reg_q,
   output logic                      locked,
   output logic [7:0]                wr_count
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (CLR_HOLD > 1) ? $clog2(CLR_HOLD + 1) : 1;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [7:0]         wr_count_q;
   logic               locked_q;

   logic [N_REQ-1:0]   gnt;
   logic [PTR_W-1:0]   gnt_idx;
   logic [PTR_W-1:0]   ptr_d;
   logic               grant_en;
   logic               hs;
   word_t              old_w, data_w, merged;
   logic [7:0]         lsb_w, len_w;
   logic [DATA_W-1:0]  reg_d;

   // Grants only in IDLE; clr and reset both hold every ready low.
   assign grant_en = (state_q == IDLE) && !clr && rst_n;

   rr_grant #(
      .N     (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_grant (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .en_i  (grant_en),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   assign req_ready = gnt;
   assign hs        = |(req_valid & gnt);
   assign ptr_d     = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

   // The grant is one-hot, so the winner's fields are gathered with an OR-mux.
   always_comb begin
      old_w  = '0;
      data_w = '0;
      lsb_w  = '0;
      len_w  = '0;
      old_w[DATA_W-1:0] = reg_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            data_w[DATA_W-1:0] = req_data[i*DATA_W +: DATA_W];
            lsb_w[OFF_W-1:0]   = req_lsb[i*OFF_W +: OFF_W];
            len_w[OFF_W-1:0]   = req_len[i*OFF_W +: OFF_W];
         end
      end
      merged = slice_merge(old_w, data_w, lsb_w, len_w);
      reg_d  = merged[DATA_W-1:0];
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock_0 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ptr_q      <= '0;
         wr_count_q <= '0;
         locked_q   <= 1'b0;
         reg_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clr) begin
                  reg_q <= '0;
                  cnt_q <= CNT_W'(CLR_HOLD);
                  if (CLR_HOLD > 0) begin
                     state_q  <= LOCK;
                     locked_q <= 1'b1;
                  end
               end else if (hs) begin
                  reg_q      <= reg_d;
                  wr_count_q <= wr_count_q + 8'd1;
                  ptr_q      <= ptr_d;
               end
            end
            LOCK: begin
               if (clr) begin
                  reg_q <= '0;
                  cnt_q <= CNT_W'(CLR_HOLD);
               end else if (cnt_q == CNT_W'(1)) begin
                  state_q  <= IDLE;
                  locked_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q  <= IDLE;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign locked   = locked_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_slice_reg_arbiter.sv
// Directed and randomized bench for slice_reg_arbiter against a bit-level reference model.
module tb_slice_reg_arbiter;

   localparam int N_REQ    = 4;
   localparam int DATA_W   = 14;
   localparam int OFF_W    = 4;
   localparam int CLR_HOLD = 2;

   logic                    clock_0;
   logic                    rst_n;
   logic                    clr;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*OFF_W-1:0]  req_lsb;
   logic [N_REQ*OFF_W-1:0]  req_len;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [DATA_W-1:0]       reg_q;
   logic                    locked;
   logic [7:0]              wr_count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DATA_W-1:0] m_reg;
   int                m_cnt;
   int                m_ptr;
   int                m_lock;

   logic [N_REQ-1:0]  rdy_seen;

   slice_reg_arbiter #(
      .N_REQ    (N_REQ),
      .DATA_W   (DATA_W),
      .OFF_W    (OFF_W),
      .CLR_HOLD (CLR_HOLD)
   ) dut (
      .clock_0   (clock_0),
      .rst_n     (rst_n),
      .clr       (clr),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_lsb   (req_lsb),
      .req_len   (req_len),
      .req_data  (req_data),
      .reg_q     (reg_q),
      .locked    (locked),
      .wr_count  (wr_count)
   );

   initial clock_0 = 1'b0;
   always #5 clock_0 = ~clock_0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input int lsb, input int len, input int data);
      req_valid[i]                = v;
      req_lsb[i*OFF_W +: OFF_W]   = OFF_W'(lsb);
      req_len[i*OFF_W +: OFF_W]   = OFF_W'(len);
      req_data[i*DATA_W +: DATA_W] = DATA_W'(data);
   endtask

   task automatic model_reset();
      m_reg  = '0;
      m_cnt  = 0;
      m_ptr  = 0;
      m_lock = 0;
   endtask

   function automatic int pick();
      for (int k = 0; k < N_REQ; k++) begin
         if (req_valid[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
      end
      return -1;
   endfunction

   // Copy data bits into positions lsb .. lsb+len-1 that exist in the register.
   task automatic model_write(input int g);
      int lsb, len;
      logic [DATA_W-1:0] d;
      lsb = int'(req_lsb[g*OFF_W +: OFF_W]);
      len = int'(req_len[g*OFF_W +: OFF_W]);
      d   = req_data[g*DATA_W +: DATA_W];
      for (int b = 0; b < DATA_W; b++) begin
         if (b >= lsb && b < lsb + len) m_reg[b] = d[b - lsb];
      end
   endtask

   // One clock: check the combinational grant, take the edge, advance the model, check the registers.
   task automatic step(output logic [N_REQ-1:0] rdy);
      int g;
      logic [N_REQ-1:0] exp_rdy;
      #1;
      g       = pick();
      exp_rdy = '0;
      if (m_lock == 0 && !clr && g >= 0) exp_rdy[g] = 1'b1;
      rdy = req_ready;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clock_0);
      if (m_lock > 0) begin
         if (clr) m_lock = CLR_HOLD;
         else     m_lock--;
      end else if (clr) begin
         m_reg  = '0;
         m_lock = CLR_HOLD;
      end else if (g >= 0) begin
         model_write(g);
         m_cnt = (m_cnt + 1) % 256;
         m_ptr = (g + 1) % N_REQ;
      end
      #1;
      check("reg_q", 32'(reg_q), 32'(m_reg));
      check("locked", 32'(locked), 32'(m_lock > 0));
      check("wr_count", 32'(wr_count), 32'(m_cnt));
   endtask

   initial begin
      rst_n     = 1'b0;
      clr       = 1'b0;
      req_valid = '1;
      req_lsb   = '0;
      req_len   = '0;
      req_data  = '0;
      model_reset();

      #12;
      check("rst_reg", 32'(reg_q), 32'h0);
      check("rst_locked", 32'(locked), 32'h0);
      check("rst_count", 32'(wr_count), 32'h0);
      check("rst_ready", 32'(req_ready), 32'h0);
      req_valid = '0;
      rst_n     = 1'b1;

      // Single write, overlap, top-edge truncation, null write
      set_req(0, 1'b1, 0, 2, 3);
      step(rdy_seen);
      check("w1_ready", 32'(rdy_seen), 32'h1);
      check("w1_reg", 32'(reg_q), 32'h3);
      check("w1_count", 32'(wr_count), 32'd1);
      set_req(0, 1'b0, 0, 0, 0);
      set_req(1, 1'b1, 1, 3, 5);
      step(rdy_seen);
      check("overlap_reg", 32'(reg_q), 32'h0B);
      set_req(1, 1'b0, 0, 0, 0);
      set_req(2, 1'b1, 12, 4, 'hF);
      step(rdy_seen);
      check("edge_reg", 32'(reg_q), 32'h300B);
      set_req(2, 1'b0, 0, 0, 0);
      set_req(3, 1'b1, 3, 0, 'h3FFF);
      step(rdy_seen);
      check("null_reg", 32'(reg_q), 32'h300B);
      check("null_count", 32'(wr_count), 32'd4);

      // Round robin: all four valid, then only 1 and 3
      for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, i * 3, 2, int'($urandom_range(0, 3)));
      for (int k = 0; k < 4; k++) begin
         step(rdy_seen);
         check("rr_all", 32'(rdy_seen), 32'(1) << k);
      end
      req_valid = 4'b1010;
      step(rdy_seen);
      check("rr_alt0", 32'(rdy_seen), 32'b0010);
      step(rdy_seen);
      check("rr_alt1", 32'(rdy_seen), 32'b1000);
      step(rdy_seen);
      check("rr_alt2", 32'(rdy_seen), 32'b0010);

      // Clear beats a same-edge write, then lockout, then req2 wins the first IDLE cycle
      req_valid = '0;
      set_req(2, 1'b1, 0, 4, 'h9);
      clr = 1'b1;
      step(rdy_seen);
      check("clr_ready", 32'(rdy_seen), 32'h0);
      check("clr_reg", 32'(reg_q), 32'h0);
      check("clr_count", 32'(wr_count), 32'd11);
      clr = 1'b0;
      step(rdy_seen);
      check("lock1_ready", 32'(rdy_seen), 32'h0);
      check("lock1_locked", 32'(locked), 32'h1);
      step(rdy_seen);
      check("lock2_ready", 32'(rdy_seen), 32'h0);
      check("lock2_locked", 32'(locked), 32'h0);
      step(rdy_seen);
      check("post_lock_grant", 32'(rdy_seen), 32'b0100);
      check("post_lock_reg", 32'(reg_q), 32'h9);

      // Clear reasserted inside the lockout restarts it
      req_valid = '0;
      clr = 1'b1;
      step(rdy_seen);
      clr = 1'b0;
      step(rdy_seen);
      clr = 1'b1;
      step(rdy_seen);
      clr = 1'b0;
      step(rdy_seen);
      check("reload_locked", 32'(locked), 32'h1);
      step(rdy_seen);
      check("reload_done", 32'(locked), 32'h0);

      // Asynchronous reset mid-handshake with a non-zero register
      set_req(0, 1'b1, 0, 15, 'h155);
      step(rdy_seen);
      check("pre_rst_reg", 32'(reg_q), 32'h155);
      set_req(0, 1'b1, 0, 15, 'h2AA);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_reg", 32'(reg_q), 32'h0);
      check("arst_locked", 32'(locked), 32'h0);
      check("arst_count", 32'(wr_count), 32'h0);
      check("arst_ready", 32'(req_ready), 32'h0);
      #2;
      rst_n = 1'b1;
      model_reset();

      // Asynchronous reset mid-lockout
      req_valid = '0;
      clr = 1'b1;
      step(rdy_seen);
      clr = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_lock_locked", 32'(locked), 32'h0);
      check("arst_lock_ready", 32'(req_ready), 32'h0);
      #2;
      rst_n = 1'b1;
      model_reset();

      // 256 writes wrap the counter back to zero
      for (int n = 0; n < 256; n++) begin
         set_req(0, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, (1 << DATA_W) - 1)));
         step(rdy_seen);
      end
      check("wrap_count", 32'(wr_count), 32'h0);

      // Randomized traffic with occasional clears
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N_REQ; i++) begin
            set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, (1 << DATA_W) - 1)));
         end
         clr = ($urandom_range(0, 11) == 0);
         step(rdy_seen);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
